eeprom_master: RTL and testbench
================================

# eeprom_master

Hardware serial master for the on-board EEPROM's two-wire bus: the initiator side of the link the `eeprom` responder implements, replacing CPU bit-banging of the IO pins. It is memory-mapped on the CPU register bus at 0x2068–0x206A. It sequences START / byte-write / byte-read / STOP frames on SCL/SDA from a programmable quarter-bit divider, and raises a completion interrupt.

## Interface
- `ADDR_BASE`, default 24'h2068: base of the 3-register window.
- `DIV_RESET`, default 8'h0F: reset value of the DIV register.
- `clk`  in  1: system clock; all logic on posedge.
- `reset`  in  1: synchronous, active-high.
- `bus_write`  in  1: CPU bus write strobe.
- `bus_read`  in  1: CPU bus read strobe.
- `bus_address_in`  in  24: bus address.
- `bus_data_in`  in  8: write data.
- `bus_data_out`  out  8: read data; 0 when the address is outside the window, so it can be OR-combined.
- `scl`  out  1: clock line; drives eeprom `ce`; 1 = released.
- `sda_out`  out  1: data line drive; drives eeprom `data_in`; 1 = released.
- `sda_in`  in  1: eeprom `data_out`.
- `irq`  out  1: one-cycle completion pulse.

One clock; reset is synchronous and active-high.

## Operation
- Registers:
  - CTRL/STATUS at base+0.
    - Write bits: 0 START, 1 WRITE, 2 READ, 3 STOP, 4 RACK (ACK to send after a read; 1 drives SDA low), 7 IE.
    - Read: {IE, busy, nack, RACK, 4'b0}.
  - DATA at base+1. Write loads the tx byte. Read returns the last rx byte.
  - DIV at base+2: read/write.
- A write to CTRL with any of bits 0–3 set, while not busy, launches a command. IE and RACK update on every CTRL write.
- While busy, writes to CTRL command bits, DATA and DIV are ignored. An IE write is still accepted.
- A command executes its set phases in the order START → WRITE or READ → STOP. If WRITE and READ are both set, only WRITE runs.
- Each phase is a sequence of quarters, and each quarter lasts DIV+1 clocks.
  - START, 4 quarters: sda=1, scl=1, sda=0, scl=0. This also serves as a repeated start.
  - WRITE, 36 quarters: 8 bits MSB first, then 1 ACK bit.
    - Each data bit: q0 sda=bit, q1 scl=1, q2 hold, q3 scl=0.
    - ACK bit: sda released; `sda_in` sampled at the end of q2 into nack.
  - READ, 36 quarters: 8 bits with sda released, each sampled at the end of q2 and shifted MSB-first; then an ACK bit with sda=~RACK. The rx byte is latched when the ACK bit ends.
  - STOP, 4 quarters: sda=0, scl=1, sda=1, hold.
- FSM states: IDLE, START, XFER_BIT, XFER_ACK, STOP.
  - Counters: 2-bit quarter counter, 3-bit bit counter, 8-bit divider counter.
  - The bit counter wraps from 7 to 0 and then enters ACK.
- On the final quarter end of the last phase: busy→0, and `irq`=IE for exactly that cycle.

## Timing
- Reset values:
  - scl=1, sda_out=1, irq=0, busy=0, nack=0.
  - IE=0, RACK=0, DATA tx/rx=0, DIV=`DIV_RESET`.
  - FSM in IDLE, all counters 0.
- Reset mid-frame: the next posedge forces the reset values. No STOP is emitted.
- `bus_data_out` is combinational from `bus_address_in`, valid whenever the address is in the window.
- Command latency:
  - CTRL written at edge n: busy reads 1 from n+1, and the first quarter begins at n+1.
  - Total length = (4·START + 36·XFER + 4·STOP) × (DIV+1) clocks.
  - busy drops and irq pulses on the last clock of that span.
- DIV=0: one clock per quarter; the minimum START+WRITE+STOP is 44 clocks.
- DIV=255: 256 clocks per quarter.
- DIV changes take effect only at the next command.
- A new command may be written in the cycle after busy falls.

## Structure
- Shared package `minx_io_pkg`:
  - Register offsets.
  - CTRL bit indices.
  - FSM state enum.
- Sub-module `quarter_tick`: loadable down-counter producing a one-cycle tick every DIV+1 clocks; restarts on command launch.
- Top-level integration:
  - The SoC ANDs `scl`/`sda_out` with the GPIO bit-bang lines, so either master may drive low.
  - Add the window to the CPU register-read decode.

## Test plan
- After reset, read 0x2068/0x2069/0x206A → 0x00/0x00/0x0F; scl=sda_out=1.
- DIV=0, DATA=0xA0, CTRL=0x83 (IE, WRITE, START), with the responder ACKing:
  - scl/sda show the START pattern, then bits 1,0,1,0,0,0,0,0.
  - busy stays high for exactly 40 clocks; then irq pulses once and STATUS=0x80 (nack=0).
- Same as above but the responder NACKs (sda_in held 1) → STATUS bit5=1 after completion.
- DIV=3, CTRL=0x1C (RACK, READ, STOP) with the responder returning 0x5A:
  - DATA reads 0x5A.
  - SDA is driven low in the ACK bit.
  - Total busy = 160 clocks; irq stays low because IE=0.
- While busy: write CTRL=0x01, DATA=0xFF, DIV=0x00 → all ignored; the in-flight frame and its timing are unchanged; the tx byte keeps its prior value.
- Assert reset at quarter 20 of a WRITE → next cycle scl=sda_out=1, busy=0, and no irq is issued.

Source files
------------

// File: rtl/minx_io_pkg.sv
// Shared definitions for the EEPROM two-wire master: register offsets,
// CTRL bit positions and FSM state encodings.
package minx_io_pkg;

  localparam logic [1:0] OFF_CTRL = 2'd0;
  localparam logic [1:0] OFF_DATA = 2'd1;
  localparam logic [1:0] OFF_DIV  = 2'd2;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_WRITE = 1;
  localparam int unsigned CTRL_READ  = 2;
  localparam int unsigned CTRL_STOP  = 3;
  localparam int unsigned CTRL_RACK  = 4;
  localparam int unsigned CTRL_IE    = 7;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_START    = 3'd1;
  localparam logic [2:0] ST_XFER_BIT = 3'd2;
  localparam logic [2:0] ST_XFER_ACK = 3'd3;
  localparam logic [2:0] ST_STOP     = 3'd4;

  function automatic logic [7:0] status_byte(input logic ie, input logic busy,
                                             input logic nack, input logic rack);
    return {ie, busy, nack, rack, 4'b0000};
  endfunction

endpackage

// File: rtl/quarter_tick.sv
// Quarter-bit timebase: emits a one-cycle tick every DIV+1 clocks while a
// frame runs; the divider is captured at command launch.
module quarter_tick (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       run,
  input  logic [7:0] div_in,
  output logic       tick
);

  logic [7:0] count;
  logic [7:0] reload;

  // Down-counter reloading from the divider captured at launch
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 8'd0;
      reload <= 8'd0;
    end else if (load) begin
      count  <= div_in;
      reload <= div_in;
    end else if (run) begin
      if (count == 8'd0) begin
        count <= reload;
      end else begin
        count <= count - 8'd1;
      end
    end
  end

  assign tick = run && !load && (count == 8'd0);

endmodule

// File: rtl/eeprom_master.sv
// Memory-mapped two-wire master for the on-board EEPROM: sequences
// START / byte-write / byte-read / STOP frames and pulses irq on completion.
module eeprom_master
  import minx_io_pkg::*;
#(
  parameter logic [23:0] ADDR_BASE = 24'h2068,
  parameter logic [7:0]  DIV_RESET = 8'h0F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [23:0] bus_address_in,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  output logic        scl,
  output logic        sda_out,
  input  logic        sda_in,
  output logic        irq
);

  logic [23:0] offset;
  logic        in_window;
  logic [1:0]  reg_sel;
  logic        ctrl_wr, data_wr, div_wr, launch, tick;

  logic [2:0]  state, nxt_state, first_state;
  logic [1:0]  qcnt, nxt_q;
  logic [2:0]  bcnt, nxt_b;
  logic        busy, ie, rack, rack_cmd, nack;
  logic        do_xfer, do_read, do_stop, cur_read;
  logic [7:0]  tx, rx, rx_shift, div;
  logic        done, smp_bit, smp_ack, rx_latch;
  logic        nxt_scl, nxt_sda;

  assign offset    = bus_address_in - ADDR_BASE;
  assign in_window = offset < 24'd3;
  assign reg_sel   = offset[1:0];
  assign ctrl_wr   = bus_write && in_window && (reg_sel == OFF_CTRL);
  assign data_wr   = bus_write && in_window && (reg_sel == OFF_DATA) && !busy;
  assign div_wr    = bus_write && in_window && (reg_sel == OFF_DIV) && !busy;
  assign launch    = ctrl_wr && !busy && (bus_data_in[3:0] != 4'b0000);
  assign cur_read  = launch ? (bus_data_in[CTRL_READ] && !bus_data_in[CTRL_WRITE]) : do_read;

  quarter_tick u_tick (
    .clk    (clk),
    .reset  (reset),
    .load   (launch),
    .run    (busy),
    .div_in (div),
    .tick   (tick)
  );

  // Phase entered first by a newly launched command
  always_comb begin
    first_state = ST_STOP;
    if (bus_data_in[CTRL_START]) begin
      first_state = ST_START;
    end else if (bus_data_in[CTRL_WRITE] || bus_data_in[CTRL_READ]) begin
      first_state = ST_XFER_BIT;
    end else begin
      first_state = ST_STOP;
    end
  end

  // Quarter/bit sequencing; the quarter counter wraps naturally at 3
  always_comb begin
    nxt_state = state;
    nxt_q     = qcnt;
    nxt_b     = bcnt;
    done      = 1'b0;
    smp_bit   = 1'b0;
    smp_ack   = 1'b0;
    rx_latch  = 1'b0;
    if (launch) begin
      nxt_state = first_state;
      nxt_q     = 2'd0;
      nxt_b     = 3'd0;
    end else if (tick) begin
      nxt_q = qcnt + 2'd1;
      case (state)
        ST_START: begin
          if (qcnt == 2'd3) begin
            if (do_xfer) begin
              nxt_state = ST_XFER_BIT;
            end else if (do_stop) begin
              nxt_state = ST_STOP;
            end else begin
              nxt_state = ST_IDLE;
              done      = 1'b1;
            end
          end else begin
            nxt_state = ST_START;
          end
        end
        ST_XFER_BIT: begin
          smp_bit = do_read && (qcnt == 2'd2);
          if (qcnt == 2'd3) begin
            nxt_b = bcnt + 3'd1;
            if (bcnt == 3'd7) begin
              nxt_state = ST_XFER_ACK;
            end else begin
              nxt_state = ST_XFER_BIT;
            end
          end else begin
            nxt_state = ST_XFER_BIT;
          end
        end
        ST_XFER_ACK: begin
          smp_ack = !do_read && (qcnt == 2'd2);
          if (qcnt == 2'd3) begin
            rx_latch = do_read;
            if (do_stop) begin
              nxt_state = ST_STOP;
            end else begin
              nxt_state = ST_IDLE;
              done      = 1'b1;
            end
          end else begin
            nxt_state = ST_XFER_ACK;
          end
        end
        ST_STOP: begin
          if (qcnt == 2'd3) begin
            nxt_state = ST_IDLE;
            done      = 1'b1;
          end else begin
            nxt_state = ST_STOP;
          end
        end
        default: nxt_state = ST_IDLE;
      endcase
    end else begin
      nxt_q = qcnt;
    end
  end

  // Line actions applied on entry to each quarter; unlisted lines hold
  always_comb begin
    nxt_scl = scl;
    nxt_sda = sda_out;
    if ((launch || tick) && (nxt_state != ST_IDLE)) begin
      case (nxt_state)
        ST_START: begin
          case (nxt_q)
            2'd0:    nxt_sda = 1'b1;
            2'd1:    nxt_scl = 1'b1;
            2'd2:    nxt_sda = 1'b0;
            default: nxt_scl = 1'b0;
          endcase
        end
        ST_XFER_BIT: begin
          case (nxt_q)
            2'd0:    nxt_sda = cur_read ? 1'b1 : tx[3'd7 - nxt_b];
            2'd1:    nxt_scl = 1'b1;
            2'd3:    nxt_scl = 1'b0;
            default: nxt_sda = sda_out;
          endcase
        end
        ST_XFER_ACK: begin
          case (nxt_q)
            2'd0:    nxt_sda = do_read ? !rack_cmd : 1'b1;
            2'd1:    nxt_scl = 1'b1;
            2'd3:    nxt_scl = 1'b0;
            default: nxt_sda = sda_out;
          endcase
        end
        ST_STOP: begin
          case (nxt_q)
            2'd0:    nxt_sda = 1'b0;
            2'd1:    nxt_scl = 1'b1;
            2'd2:    nxt_sda = 1'b1;
            default: nxt_sda = sda_out;
          endcase
        end
        default: nxt_sda = sda_out;
      endcase
    end else begin
      nxt_scl = scl;
      nxt_sda = sda_out;
    end
  end

  // Registers, command capture and bus-side register file
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      qcnt     <= 2'd0;
      bcnt     <= 3'd0;
      busy     <= 1'b0;
      ie       <= 1'b0;
      rack     <= 1'b0;
      rack_cmd <= 1'b0;
      nack     <= 1'b0;
      do_xfer  <= 1'b0;
      do_read  <= 1'b0;
      do_stop  <= 1'b0;
      tx       <= 8'h00;
      rx       <= 8'h00;
      rx_shift <= 8'h00;
      div      <= DIV_RESET;
      scl      <= 1'b1;
      sda_out  <= 1'b1;
      irq      <= 1'b0;
    end else begin
      state   <= nxt_state;
      qcnt    <= nxt_q;
      bcnt    <= nxt_b;
      scl     <= nxt_scl;
      sda_out <= nxt_sda;
      irq     <= done && ie;
      if (launch) begin
        busy     <= 1'b1;
        do_xfer  <= bus_data_in[CTRL_WRITE] || bus_data_in[CTRL_READ];
        do_read  <= bus_data_in[CTRL_READ] && !bus_data_in[CTRL_WRITE];
        do_stop  <= bus_data_in[CTRL_STOP];
        rack_cmd <= bus_data_in[CTRL_RACK];
      end else if (done) begin
        busy <= 1'b0;
      end
      if (ctrl_wr) begin
        ie   <= bus_data_in[CTRL_IE];
        rack <= bus_data_in[CTRL_RACK];
      end
      if (data_wr) begin
        tx <= bus_data_in;
      end
      if (div_wr) begin
        div <= bus_data_in;
      end
      if (smp_bit) begin
        rx_shift <= {rx_shift[6:0], sda_in};
      end
      if (smp_ack) begin
        nack <= sda_in;
      end
      if (rx_latch) begin
        rx <= rx_shift;
      end
    end
  end

  // Read mux; zero outside the window so several peripherals can be ORed
  always_comb begin
    bus_data_out = 8'h00;
    if (bus_read && in_window) begin
      case (reg_sel)
        OFF_CTRL: bus_data_out = status_byte(ie, busy, nack, rack);
        OFF_DATA: bus_data_out = rx;
        OFF_DIV:  bus_data_out = div;
        default:  bus_data_out = 8'h00;
      endcase
    end else begin
      bus_data_out = 8'h00;
    end
  end

endmodule

// File: tb/tb_eeprom_master.sv
// Bench for eeprom_master: directed and randomized frames compared quarter by
// quarter against a phase-list model of the two-wire waveform.
module tb_eeprom_master;

  localparam logic [23:0] BASE = 24'h2068;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_write = 1'b0;
  logic        bus_read = 1'b0;
  logic [23:0] bus_address_in = BASE;
  logic [7:0]  bus_data_in = 8'h00;
  logic [7:0]  bus_data_out;
  logic        scl, sda_out, sda_in, irq;

  eeprom_master dut (
    .clk            (clk),
    .reset          (reset),
    .bus_write      (bus_write),
    .bus_read       (bus_read),
    .bus_address_in (bus_address_in),
    .bus_data_in    (bus_data_in),
    .bus_data_out   (bus_data_out),
    .scl            (scl),
    .sda_out        (sda_out),
    .sda_in         (sda_in),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  // Responder: shifts a read byte out, advancing on each falling scl
  int         scl_falls = 0;
  int         fall_base = 0;
  logic       rd_mode = 1'b0;
  logic [7:0] rd_byte = 8'h00;
  logic       ack_lvl = 1'b0;

  always @(negedge scl) scl_falls <= scl_falls + 1;

  always_comb begin
    int k;
    k = scl_falls - fall_base;
    if (!rd_mode) sda_in = ack_lvl;
    else if (k >= 0 && k < 8) sda_in = rd_byte[7 - k];
    else sda_in = 1'b1;
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_div = 8'h0F, m_tx = 8'h00, m_rx = 8'h00;
  logic       m_ie = 1'b0, m_rack = 1'b0, m_nack = 1'b0;
  logic       m_scl = 1'b1, m_sda = 1'b1;
  bit         exp_scl[$];
  bit         exp_sda[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] off, output logic [7:0] v);
    bus_address_in = BASE + {22'd0, off};
    bus_read = 1'b1;
    #1;
    v = bus_data_out;
    bus_read = 1'b0;
  endtask

  task automatic reg_write(input logic [1:0] off, input logic [7:0] d);
    bus_address_in = BASE + {22'd0, off};
    bus_data_in = d;
    bus_write = 1'b1;
    @(posedge clk); #1;
    bus_write = 1'b0;
    if (off == 2'd1) m_tx = d;
    if (off == 2'd2) m_div = d;
  endtask

  task automatic model_reset();
    m_div = 8'h0F; m_tx = 8'h00; m_rx = 8'h00;
    m_ie = 1'b0; m_rack = 1'b0; m_nack = 1'b0;
    m_scl = 1'b1; m_sda = 1'b1;
  endtask

  // One quarter of the expected waveform; -1 leaves that line as it was
  task automatic put_q(input int s, input int d);
    if (s >= 0) m_scl = s[0];
    if (d >= 0) m_sda = d[0];
    exp_scl.push_back(m_scl);
    exp_sda.push_back(m_sda);
  endtask

  task automatic put_bit(input int d);
    put_q(-1, d); put_q(1, -1); put_q(-1, -1); put_q(0, -1);
  endtask

  task automatic build(input logic [7:0] ctrl);
    exp_scl.delete();
    exp_sda.delete();
    if (ctrl[0]) begin
      put_q(-1, 1); put_q(1, -1); put_q(-1, 0); put_q(0, -1);
    end
    if (ctrl[1]) begin
      for (int i = 7; i >= 0; i--) put_bit(int'(m_tx[i]));
      put_bit(1);
    end else if (ctrl[2]) begin
      for (int i = 0; i < 8; i++) put_bit(1);
      put_bit(ctrl[4] ? 0 : 1);
    end
    if (ctrl[3]) begin
      put_q(-1, 0); put_q(1, -1); put_q(-1, 1); put_q(-1, -1);
    end
  endtask

  // inject: 0 none, 1 register writes while busy, 2 reset at quarter 20
  task automatic run_cmd(input logic [7:0] ctrl, input logic [7:0] rbyte,
                         input logic nk, input int inject);
    int nq, per, total;
    logic [7:0] v;
    bit aborted;
    m_ie = ctrl[7];
    m_rack = ctrl[4];
    build(ctrl);
    nq = exp_scl.size();
    per = int'(m_div) + 1;
    total = nq * per;
    rd_mode = ctrl[2] && !ctrl[1];
    rd_byte = rbyte;
    ack_lvl = nk;
    fall_base = scl_falls + (ctrl[0] ? 1 : 0);
    bus_address_in = BASE;
    bus_data_in = ctrl;
    bus_write = 1'b1;
    @(posedge clk); #1;
    bus_write = 1'b0;
    aborted = 1'b0;
    for (int c = 0; c < total; c++) begin
      if (c % per == 0) begin
        chk("scl", {7'd0, scl}, {7'd0, exp_scl[c / per]});
        chk("sda", {7'd0, sda_out}, {7'd0, exp_sda[c / per]});
        rd(2'd0, v);
        chk("busy", {7'd0, v[6]}, 8'd1);
        chk("irq_mid", {7'd0, irq}, 8'd0);
      end
      if (inject == 1) begin
        if (c == 8) begin
          bus_address_in = BASE; bus_data_in = 8'h01; bus_write = 1'b1;
          m_ie = 1'b0; m_rack = 1'b0;
        end else if (c == 9) begin
          bus_address_in = BASE + 24'd1; bus_data_in = 8'hFF;
        end else if (c == 10) begin
          bus_address_in = BASE + 24'd2; bus_data_in = 8'h00;
        end else if (c == 11) begin
          bus_write = 1'b0;
        end
      end
      if (inject == 2 && c == 20 * per) begin
        reset = 1'b1;
        @(posedge clk); #1;
        aborted = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!aborted) begin
      if (ctrl[1]) m_nack = nk;
      else if (ctrl[2]) m_rx = rbyte;
      chk("irq_end", {7'd0, irq}, {7'd0, m_ie});
      rd(2'd0, v);
      chk("status_end", v, {m_ie, 1'b0, m_nack, m_rack, 4'b0000});
      rd(2'd1, v);
      chk("rx_data", v, m_rx);
      @(posedge clk); #1;
      chk("irq_once", {7'd0, irq}, 8'd0);
    end
    rd_mode = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] c8;
    bit irq_seen, scl_low;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", {7'd0, scl}, 8'd1);
    chk("rst_sda", {7'd0, sda_out}, 8'd1);
    chk("rst_irq", {7'd0, irq}, 8'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    rd(2'd0, v); chk("rst_status", v, 8'h00);
    rd(2'd1, v); chk("rst_data", v, 8'h00);
    rd(2'd2, v); chk("rst_div", v, 8'h0F);
    rd(2'd3, v); chk("outside_window", v, 8'h00);

    // START+WRITE 0xA0 at DIV=0, responder ACKs, then NACKs
    reg_write(2'd2, 8'h00);
    reg_write(2'd1, 8'hA0);
    run_cmd(8'h83, 8'h00, 1'b0, 0);
    run_cmd(8'h83, 8'h00, 1'b1, 0);

    // READ+STOP with RACK at DIV=3, responder returns 0x5A
    reg_write(2'd2, 8'h03);
    run_cmd(8'h1C, 8'h5A, 1'b0, 0);

    // Register writes while busy must not disturb the frame
    reg_write(2'd1, 8'h3C);
    run_cmd(8'h0A, 8'h00, 1'b0, 1);
    rd(2'd2, v); chk("div_kept", v, 8'h03);
    run_cmd(8'h0A, 8'h00, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      c8 = 8'($urandom) & 8'h9F;
      if (c8[3:0] == 4'd0) c8[1] = 1'b1;
      reg_write(2'd2, 8'($urandom_range(0, 3)));
      reg_write(2'd1, 8'($urandom));
      run_cmd(c8, 8'($urandom), 1'($urandom), 0);
    end

    // Reset in the middle of a WRITE: lines released at once, no irq
    reg_write(2'd2, 8'h01);
    reg_write(2'd1, 8'($urandom));
    run_cmd(8'h8B, 8'h00, 1'b0, 2);
    model_reset();
    chk("midrst_scl", {7'd0, scl}, 8'd1);
    chk("midrst_sda", {7'd0, sda_out}, 8'd1);
    chk("midrst_irq", {7'd0, irq}, 8'd0);
    rd(2'd0, v); chk("midrst_status", v, 8'h00);
    reset = 1'b0;
    irq_seen = 1'b0;
    scl_low = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (irq !== 1'b0) irq_seen = 1'b1;
      if (scl !== 1'b1) scl_low = 1'b1;
    end
    chk("no_irq_after_rst", {7'd0, irq_seen}, 8'd0);
    chk("scl_idle_after_rst", {7'd0, scl_low}, 8'd0);
    rd(2'd2, v); chk("midrst_div", v, m_div);
    rd(2'd1, v); chk("midrst_data", v, m_rx);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
